// File: rtl/placement_cost_eval.sv
// Walks the edge list, fetches both endpoint positions per edge and accumulates
// Manhattan wirelength statistics; aborts on the first unplaced/off-grid endpoint.
module placement_cost_eval #(
   parameter int N      = 9,
   parameter int N_EDGE = 76
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               ea_re,
   output logic               eb_re,
   output logic        [31:0] ea_addr,
   output logic        [31:0] eb_addr,
   input  logic signed [31:0] ea_data,
   input  logic signed [31:0] eb_data,
   output logic               px_re,
   output logic               py_re,
   output logic        [31:0] px_addr,
   output logic        [31:0] py_addr,
   input  logic signed [31:0] px_data,
   input  logic signed [31:0] py_data,
   output logic signed [31:0] sum,
   output logic        [31:0] max_len,
   output logic        [31:0] long_cnt,
   output logic               err,
   output logic        [31:0] err_edge
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_EDGE,
      S_EW,
      S_PA,
      S_PAW,
      S_PB,
      S_PBW,
      S_ACC,
      S_DONE
   } state_t;

   localparam logic signed [31:0] LP_CMAX = 32'(N - 1);
   localparam logic        [31:0] LP_LAST = 32'(N_EDGE - 1);

   state_t             r_state;
   logic        [31:0] r_i;
   logic signed [31:0] r_a;
   logic signed [31:0] r_b;
   logic signed [31:0] r_ax;
   logic signed [31:0] r_ay;
   logic signed [31:0] r_bx;
   logic signed [31:0] r_by;
   logic signed [31:0] r_sum;
   logic        [31:0] r_max_len;
   logic        [31:0] r_long_cnt;
   logic               r_err;
   logic        [31:0] r_err_edge;

   logic               w_pos_ok;
   logic signed [31:0] w_dx_raw;
   logic signed [31:0] w_dy_raw;
   logic signed [31:0] w_dx;
   logic signed [31:0] w_dy;
   logic signed [31:0] w_len_m1;
   logic signed [31:0] w_len;
   logic               w_len_nz;

   // Position read this cycle (PAW/PBW) must lie on the N x N grid; -1 marks unplaced.
   assign w_pos_ok = (px_data >= 32'sd0) && (px_data <= LP_CMAX) &&
                     (py_data >= 32'sd0) && (py_data <= LP_CMAX);

   assign w_dx_raw = r_ax - r_bx;
   assign w_dy_raw = r_ay - r_by;
   assign w_dx     = w_dx_raw[31] ? -w_dx_raw : w_dx_raw;
   assign w_dy     = w_dy_raw[31] ? -w_dy_raw : w_dy_raw;
   assign w_len_m1 = w_dx + w_dy - 32'sd1;
   assign w_len    = w_len_m1[31] ? '0 : w_len_m1;
   assign w_len_nz = (w_len != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_i        <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_ax       <= '0;
         r_ay       <= '0;
         r_bx       <= '0;
         r_by       <= '0;
         r_sum      <= '0;
         r_max_len  <= '0;
         r_long_cnt <= '0;
         r_err      <= 1'b0;
         r_err_edge <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sum      <= '0;
                  r_max_len  <= '0;
                  r_long_cnt <= '0;
                  r_err      <= 1'b0;
                  r_err_edge <= '0;
                  r_i        <= '0;
                  r_state    <= (N_EDGE == 0) ? S_DONE : S_EDGE;
               end
            end
            S_EDGE: r_state <= S_EW;
            S_EW: begin
               r_a     <= ea_data;
               r_b     <= eb_data;
               r_state <= S_PA;
            end
            S_PA: r_state <= S_PAW;
            S_PAW: begin
               r_ax <= px_data;
               r_ay <= py_data;
               if (!w_pos_ok) begin
                  r_err      <= 1'b1;
                  r_err_edge <= r_i;
                  r_state    <= S_DONE;
               end else begin
                  r_state <= S_PB;
               end
            end
            S_PB: r_state <= S_PBW;
            S_PBW: begin
               r_bx <= px_data;
               r_by <= py_data;
               if (!w_pos_ok) begin
                  r_err      <= 1'b1;
                  r_err_edge <= r_i;
                  r_state    <= S_DONE;
               end else begin
                  r_state <= S_ACC;
               end
            end
            S_ACC: begin
               r_sum      <= r_sum + w_len;
               r_max_len  <= ($unsigned(w_len) > r_max_len) ? $unsigned(w_len) : r_max_len;
               r_long_cnt <= r_long_cnt + {31'b0, w_len_nz};
               r_i        <= r_i + 32'd1;
               r_state    <= (r_i == LP_LAST) ? S_DONE : S_EDGE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Memory handshakes are pure state decodes so an async reset drops them instantly.
   always_comb begin
      ea_re   = 1'b0;
      eb_re   = 1'b0;
      ea_addr = '0;
      eb_addr = '0;
      px_re   = 1'b0;
      py_re   = 1'b0;
      px_addr = '0;
      py_addr = '0;
      case (r_state)
         S_EDGE: begin
            ea_re   = 1'b1;
            eb_re   = 1'b1;
            ea_addr = r_i;
            eb_addr = r_i;
         end
         S_PA: begin
            px_re   = 1'b1;
            py_re   = 1'b1;
            px_addr = r_a;
            py_addr = r_a;
         end
         S_PB: begin
            px_re   = 1'b1;
            py_re   = 1'b1;
            px_addr = r_b;
            py_addr = r_b;
         end
         default: ;
      endcase
   end

   assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done     = (r_state == S_DONE);
   assign sum      = r_sum;
   assign max_len  = r_max_len;
   assign long_cnt = r_long_cnt;
   assign err      = r_err;
   assign err_edge = r_err_edge;

endmodule

// File: doc/placement_cost_eval.md
# placement_cost_eval

Downstream evaluation stage for the placement engine. After placement has filled the position X/Y RAMs, this block walks the edge list (EA/EB ROMs) and reads both endpoint positions for every edge. It accumulates the total Manhattan wirelength, the longest edge and the count of non-adjacent edges, and flags any endpoint left unplaced or off-grid. It shares the edge ROMs and position RAMs through read-only ports; placement must be idle while it runs.

## Interface
- `N`, 9, grid side; a valid coordinate is 0..N-1.
- `N_EDGE`, 76, number of edges to evaluate (edge indices 0..N_EDGE-1).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; one clock domain only.
- `start`  in  1  begin evaluation; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  one-cycle pulse when results are valid.
- `ea_re`, `eb_re`  out  1  edge ROM read enables.
- `ea_addr`, `eb_addr`  out  32  edge index.
- `ea_data`, `eb_data`  in  32 signed  endpoint node ids a, b.
- `px_re`, `py_re`  out  1  position RAM read enables.
- `px_addr`, `py_addr`  out  32  node id.
- `px_data`, `py_data`  in  32 signed  node X / Y.
- `sum`  out  32 signed  total of per-edge lengths.
- `max_len`  out  32  largest per-edge length.
- `long_cnt`  out  32  number of edges with length > 0.
- `err`  out  1  invalid position encountered.
- `err_edge`  out  32  index of the first failing edge.

## Operation
- Memory contract: the memory samples `re`/addr at the end of the cycle in which they are asserted. Data is stable for the whole following cycle.
- Read enables and addresses are combinational decodes of the state. They are 0 outside EDGE, PA and PB.
- FSM states and transitions:
  - IDLE: on `start`, clear the result registers, set i=0, then go to EDGE. If N_EDGE=0, go straight to DONE.
  - EDGE: `ea_re`=`eb_re`=1, addr=i. Next state EW.
  - EW: latch a=`ea_data`, b=`eb_data`. Next state PA.
  - PA: `px_re`=`py_re`=1, addr=a. Next state PAW.
  - PAW: latch ax, ay. If either is outside 0..N-1 (including -1 = unplaced), set err=1, err_edge=i, go to DONE. Otherwise go to PB.
  - PB: `px_re`=`py_re`=1, addr=b. Next state PBW.
  - PBW: latch bx, by. Apply the same range check as PAW, then go to ACC.
  - ACC: compute the edge length and update the results (rules below), then i=i+1. Go to DONE if the new i equals N_EDGE, otherwise to EDGE.
  - DONE: `done`=1 for this one cycle, then go to IDLE.
- Length arithmetic, all 32-bit signed:
  - dx=|ax-bx|, dy=|ay-by|; absolute value by two's complement negate when negative.
  - len = dx+dy-1, clamped to 0 when negative (self-loop a==b).
  - sum += len; max_len = max(max_len, len); long_cnt += (len>0).
- Results hold their values in IDLE until the next accepted `start`. On error, the partial sums cover edges 0..err_edge-1.
- `start` while busy or in DONE is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`=0; `sum`, `max_len`, `long_cnt`, `err_edge`, i=0; all read enables and addresses 0.
- Each edge takes exactly 7 cycles (EDGE through ACC).
- With `start` sampled at edge t0, the first EDGE is cycle t0+1. `done` is high during cycle t0+1+7·N_EDGE.
- On an error at edge k:
  - failing in PAW: `done` at t0+7k+5;
  - failing in PBW: `done` at t0+7k+7.
- N_EDGE=0: `done` at t0+1 with all results 0.
- `reset` asserted mid-run: every output returns to its reset value immediately (asynchronously), and read enables drop in the same instant. The evaluation is not resumed; a new `start` is required.

## Test plan
- Two edges, N_EDGE=2: edges (0,1) and (1,2); positions 0=(0,0), 1=(0,1), 2=(3,4). Expected: sum=5, max_len=5, long_cnt=1, err=0, `done` exactly 15 cycles after `start`.
- Negative difference: edge (3,4) with 3=(8,8), 4=(0,2). Expected: len=13, sum=13; confirms the absolute value is taken on both axes.
- Unplaced endpoint: edge 1 has b with X=-1. Expected: err=1, err_edge=1, sum equals edge 0's length only, `done` at t0+14.
- Off-grid endpoint: a at X=9 on edge 0. Expected: err=1, err_edge=0, `done` at t0+5.
- Self-loop: edge (5,5). Expected: len clamped to 0, long_cnt unchanged.
- Control:
  - pulse `start` during EDGE of edge 1: ignored, results unchanged;
  - assert `reset` at cycle 10: all outputs 0 within the same cycle;
  - rerun after reset: matches the clean run bit-exactly.
